// File: rtl/svunit_hw_test_sequencer.sv
// Hardware test runner: walks enabled suites, issuing setup/test/teardown transactions over req/ack,
// tallying pass/fail/timeout/skip results and producing per-suite and overall verdicts.
module svunit_hw_test_sequencer #(
  parameter int NUM_SUITES     = 4,
  parameter int MAX_TESTS      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  localparam int SW = (NUM_SUITES > 1) ? $clog2(NUM_SUITES) : 1,
  localparam int TW = $clog2(MAX_TESTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_SUITES-1:0]    suite_enable,
  input  logic [NUM_SUITES*TW-1:0] suite_num_tests,
  input  logic                     stop_on_fail,
  output logic                     req,
  output logic [1:0]               phase,
  output logic [SW-1:0]            suite_id,
  output logic [TW-1:0]            test_id,
  input  logic                     ack,
  input  logic                     ack_pass,
  output logic                     busy,
  output logic                     done,
  output logic                     overall_pass,
  output logic [NUM_SUITES-1:0]    suite_pass,
  output logic [CNT_W-1:0]         pass_count,
  output logic [CNT_W-1:0]         fail_count,
  output logic [CNT_W-1:0]         timeout_count,
  output logic [CNT_W-1:0]         skip_count
);
  localparam int OW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [OW-1:0] TMO_LAST = OW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] MAX_T    = TW'(MAX_TESTS);
  localparam logic [SW:0]   NS_L     = (SW + 1)'(NUM_SUITES);

  typedef enum logic [2:0] {IDLE, SCAN, SETUP, TEST, TEARDOWN, GAP, REPORT} state_t;

  state_t                state, state_n, gap_q, gap_n;
  logic [SW:0]           idx;
  logic [SW-1:0]         sidx;
  logic [TW-1:0]         tid, tid_n, cur_num, remaining;
  logic [OW-1:0]         tmo_cnt;
  logic [NUM_SUITES-1:0] en_q;
  logic [TW-1:0]         num_q [NUM_SUITES];
  logic                  stop_q, failed_q, overall_q;
  logic                  in_txn, timed_out, txn_done, txn_pass, suite_failed, overall_calc;
  logic                  latch, idx_inc, add_pass, add_fail, add_tmo, fail_set, verdict_wr;
  logic [31:0]           later_sum, skip_add;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [31:0] b);
    logic [CNT_W+32:0] s;
    s = {33'd0, a} + {{(CNT_W + 1){1'b0}}, b};
    return (s > {33'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign sidx         = idx[SW-1:0];
  assign cur_num      = (idx < NS_L) ? num_q[sidx] : '0;
  assign remaining    = cur_num - tid - TW'(1);
  assign in_txn       = (state == SETUP) || (state == TEST) || (state == TEARDOWN);
  assign timed_out    = in_txn && !ack && (tmo_cnt == TMO_LAST);
  assign txn_done     = in_txn && (ack || (tmo_cnt == TMO_LAST));
  assign txn_pass     = ack && ack_pass;
  assign suite_failed = failed_q || !txn_pass;
  assign overall_calc = (fail_count == '0) && ((suite_pass & en_q) == en_q) && (|en_q);

  assign req          = in_txn;
  assign busy         = (state != IDLE);
  assign done         = (state == REPORT);
  assign overall_pass = done ? overall_calc : overall_q;
  assign suite_id     = sidx;
  assign test_id      = (state == TEST) ? tid : '0;
  assign phase        = (state == TEST) ? 2'd1 : (state == TEARDOWN) ? 2'd2 : 2'd0;

  // Tests still owed by enabled suites after the current one, skipped on a stop-on-fail abort
  always_comb begin
    later_sum = '0;
    for (int i = 0; i < NUM_SUITES; i++)
      if (en_q[i] && ((SW + 1)'(i) > idx)) later_sum = later_sum + 32'(num_q[i]);
  end

  always_comb begin
    state_n    = state;
    gap_n      = gap_q;
    tid_n      = tid;
    latch      = 1'b0;
    idx_inc    = 1'b0;
    add_pass   = 1'b0;
    add_fail   = 1'b0;
    add_tmo    = 1'b0;
    fail_set   = 1'b0;
    verdict_wr = 1'b0;
    skip_add   = '0;
    case (state)
      IDLE: if (start) begin
        latch   = 1'b1;
        state_n = SCAN;
      end
      SCAN: begin
        if (idx >= NS_L)     state_n = REPORT;
        else if (en_q[sidx]) state_n = SETUP;
        else                 idx_inc = 1'b1;
      end
      SETUP: if (txn_done) begin
        state_n = GAP;
        tid_n   = '0;
        if (txn_pass) gap_n = (cur_num == '0) ? TEARDOWN : TEST;
        else begin
          fail_set = 1'b1;
          skip_add = 32'(cur_num);
          gap_n    = TEARDOWN;
        end
      end
      TEST: if (txn_done) begin
        state_n = GAP;
        if (txn_pass) add_pass = 1'b1;
        else begin
          add_fail = 1'b1;
          fail_set = 1'b1;
          add_tmo  = timed_out;
        end
        if (!txn_pass && stop_q) begin
          skip_add = 32'(remaining);
          gap_n    = TEARDOWN;
        end else if (remaining == '0) begin
          gap_n = TEARDOWN;
        end else begin
          tid_n = tid + TW'(1);
          gap_n = TEST;
        end
      end
      TEARDOWN: if (txn_done) begin
        verdict_wr = 1'b1;
        if (stop_q && suite_failed) begin
          skip_add = later_sum;
          state_n  = REPORT;
        end else begin
          idx_inc = 1'b1;
          state_n = SCAN;
        end
      end
      GAP:     state_n = gap_q;
      REPORT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gap_q         <= IDLE;
      idx           <= '0;
      tid           <= '0;
      tmo_cnt       <= '0;
      en_q          <= '0;
      stop_q        <= 1'b0;
      failed_q      <= 1'b0;
      overall_q     <= 1'b0;
      suite_pass    <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
      timeout_count <= '0;
      skip_count    <= '0;
      for (int i = 0; i < NUM_SUITES; i++) num_q[i] <= '0;
    end else begin
      state   <= state_n;
      gap_q   <= gap_n;
      tid     <= tid_n;
      tmo_cnt <= (in_txn && !txn_done) ? tmo_cnt + OW'(1) : '0;
      if (latch) begin
        en_q          <= suite_enable;
        stop_q        <= stop_on_fail;
        idx           <= '0;
        failed_q      <= 1'b0;
        overall_q     <= 1'b0;
        suite_pass    <= '0;
        pass_count    <= '0;
        fail_count    <= '0;
        timeout_count <= '0;
        skip_count    <= '0;
        for (int i = 0; i < NUM_SUITES; i++)
          num_q[i] <= (suite_num_tests[i*TW +: TW] > MAX_T) ? MAX_T : suite_num_tests[i*TW +: TW];
      end
      if (idx_inc) begin
        idx      <= idx + (SW + 1)'(1);
        failed_q <= 1'b0;
      end
      if (fail_set)           failed_q         <= 1'b1;
      if (verdict_wr)         suite_pass[sidx] <= !suite_failed;
      if (add_pass)           pass_count       <= sat_add(pass_count, 32'd1);
      if (add_fail)           fail_count       <= sat_add(fail_count, 32'd1);
      if (add_tmo)            timeout_count    <= sat_add(timeout_count, 32'd1);
      if (skip_add != '0)     skip_count       <= sat_add(skip_count, skip_add);
      if (state == REPORT)    overall_q        <= overall_calc;
    end
  end
endmodule

// File: tb/tb_svunit_hw_test_sequencer.sv
// Bench for svunit_hw_test_sequencer: a scripted agent answers each request from a pre-drawn outcome
// list, and a suite-by-suite reference model predicts the transaction order and final tallies.
module tb_svunit_hw_test_sequencer;
  localparam int NS = 3, MT = 5, TO = 8, CW = 16;
  localparam int SW = 2, TW = 3;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop_on_fail = 1'b0, ack = 1'b0, ack_pass = 1'b0;
  logic [NS-1:0]    suite_enable = '0;
  logic [NS*TW-1:0] suite_num_tests = '0;
  logic req, busy, done, overall_pass;
  logic [1:0] phase;
  logic [SW-1:0] suite_id;
  logic [TW-1:0] test_id;
  logic [NS-1:0] suite_pass;
  logic [CW-1:0] pass_count, fail_count, timeout_count, skip_count;

  svunit_hw_test_sequencer #(.NUM_SUITES(NS), .MAX_TESTS(MT), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .suite_enable(suite_enable),
    .suite_num_tests(suite_num_tests), .stop_on_fail(stop_on_fail), .req(req), .phase(phase),
    .suite_id(suite_id), .test_id(test_id), .ack(ack), .ack_pass(ack_pass), .busy(busy),
    .done(done), .overall_pass(overall_pass), .suite_pass(suite_pass), .pass_count(pass_count),
    .fail_count(fail_count), .timeout_count(timeout_count), .skip_count(skip_count));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int out_d [64];
  bit out_p [64];
  int exp_ph [64], exp_su [64], exp_te [64], exp_dur [64];
  int exp_n = 0;
  int e_pass, e_fail, e_tmo, e_skip;
  logic [NS-1:0] e_sp;
  logic e_ov;
  int k = 0, cur = 0, hi = 0;
  bit prev_req = 1'b0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Agent: the k-th request gets outcome k; ack noise while req is low must be ignored.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack = 1'b0; ack_pass = 1'b0; prev_req = 1'b0; hi = 0;
    end else if (req) begin
      if (!prev_req) begin
        if (k < exp_n)
          check_val("txn_id", phase * 64 + suite_id * 8 + test_id, exp_ph[k] * 64 + exp_su[k] * 8 + exp_te[k]);
        else
          check_val("txn_extra", k, exp_n);
        cur = (k < 63) ? k : 63;
        k++;
        hi = 0;
      end
      ack      = (hi == out_d[cur]);
      ack_pass = ack ? out_p[cur] : 1'($urandom);
      hi++;
    end else begin
      if (prev_req) check_val("req_len", hi, (cur < exp_n) ? exp_dur[cur] : 0);
      ack      = 1'($urandom);
      ack_pass = 1'($urandom);
    end
    prev_req = req;
  end

  task automatic push(input int ph, input int s, input int t, output bit ok, output bit tmo);
    tmo = (out_d[exp_n] >= TO);
    ok  = out_p[exp_n] && !tmo;
    exp_ph[exp_n] = ph; exp_su[exp_n] = s; exp_te[exp_n] = t;
    exp_dur[exp_n] = tmo ? TO : out_d[exp_n] + 1;
    exp_n++;
  endtask

  task automatic model(input logic [NS-1:0] en, input logic [NS*TW-1:0] nums, input logic stop);
    int n [NS];
    bit failed, ok, tmo, halt;
    halt = 1'b0;
    exp_n = 0; e_pass = 0; e_fail = 0; e_tmo = 0; e_skip = 0; e_sp = '0;
    for (int s = 0; s < NS; s++) n[s] = (int'(nums[s*TW +: TW]) > MT) ? MT : int'(nums[s*TW +: TW]);
    for (int s = 0; s < NS; s++) begin
      if (!en[s]) continue;
      if (halt) begin e_skip += n[s]; continue; end
      failed = 1'b0;
      push(0, s, 0, ok, tmo);
      if (!ok) begin failed = 1'b1; e_skip += n[s]; end
      else for (int t = 0; t < n[s]; t++) begin
        push(1, s, t, ok, tmo);
        if (ok) e_pass++;
        else begin
          e_fail++; failed = 1'b1;
          if (tmo) e_tmo++;
          if (stop) begin e_skip += n[s] - t - 1; break; end
        end
      end
      push(2, s, 0, ok, tmo);
      if (!ok) failed = 1'b1;
      e_sp[s] = !failed;
      if (stop && failed) halt = 1'b1;
    end
    e_ov = (e_fail == 0) && ((e_sp & en) == en) && (en != '0);
  endtask

  task automatic set_outs(input int d, input bit p);
    for (int i = 0; i < 64; i++) begin out_d[i] = d; out_p[i] = p; end
  endtask

  task automatic gen_outs(input int fail_pct, input int tmo_pct);
    for (int i = 0; i < 64; i++) begin
      out_d[i] = ($urandom_range(99) < tmo_pct) ? TO + $urandom_range(2) : $urandom_range(3);
      out_p[i] = ($urandom_range(99) >= fail_pct);
    end
  endtask

  task automatic do_run(input logic [NS-1:0] en, input logic [NS*TW-1:0] nums, input logic stop,
                        input bit inject, output int busy_cyc);
    bit got_done;
    int inj_at;
    got_done = 1'b0; busy_cyc = 0; inj_at = 2 + $urandom_range(20);
    model(en, nums, stop);
    k = 0;
    @(negedge clk);
    suite_enable = en; suite_num_tests = nums; stop_on_fail = stop; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    suite_enable = NS'($urandom); suite_num_tests = (NS*TW)'($urandom); stop_on_fail = 1'($urandom);
    check_val("busy_rise", busy, 1);
    for (int c = 0; c < 2000; c++) begin
      if (done) begin got_done = 1'b1; break; end
      busy_cyc++;
      start = inject && (c == inj_at);
      @(negedge clk);
    end
    start = 1'b0;
    check_val("done_seen", got_done, 1);
    if (got_done) begin
      check_val("pass_count", pass_count, e_pass);
      check_val("fail_count", fail_count, e_fail);
      check_val("timeout_count", timeout_count, e_tmo);
      check_val("skip_count", skip_count, e_skip);
      check_val("suite_pass", suite_pass, e_sp);
      check_val("overall_at_done", overall_pass, e_ov);
      check_val("busy_at_done", busy, 1);
      check_val("txn_total", k, exp_n);
      @(negedge clk);
      check_val("done_single", done, 0);
      check_val("busy_fall", busy, 0);
      check_val("overall_hold", overall_pass, e_ov);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    logic [NS-1:0] en;
    bc = 0;
    #12;
    check_val("rst_req", req, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_counts", pass_count + fail_count + timeout_count + skip_count, 0);
    check_val("rst_verdicts", {suite_pass, overall_pass, phase}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    set_outs(1, 1'b1);                                   // all pass, 1-cycle ack
    do_run(3'b011, {3'd0, 3'd2, 3'd3}, 1'b0, 1'b0, bc);
    set_outs(0, 1'b1); out_p[2] = 1'b0;                  // suite 0 test 1 fails, stop on fail
    do_run(3'b011, {3'd0, 3'd2, 3'd4}, 1'b1, 1'b0, bc);
    set_outs(0, 1'b1); out_d[1] = 50;                    // test 0 never acked
    do_run(3'b001, {3'd0, 3'd0, 3'd2}, 1'b0, 1'b0, bc);
    set_outs(2, 1'b1); out_p[0] = 1'b0;                  // setup fails
    do_run(3'b001, {3'd0, 3'd0, 3'd3}, 1'b0, 1'b0, bc);
    do_run(3'b000, {3'd1, 3'd1, 3'd1}, 1'b0, 1'b1, bc);
    check_val("scan_only_cycles", bc, NS + 1);
    set_outs(0, 1'b1);                                   // counts above MAX_TESTS clamp
    do_run(3'b111, {3'd5, 3'd6, 3'd7}, 1'b0, 1'b1, bc);

    // Reset in the middle of the second test of suite 0
    set_outs(3, 1'b1);
    model(3'b111, {3'd5, 3'd5, 3'd5}, 1'b0);
    k = 0;
    @(negedge clk);
    suite_enable = 3'b111; suite_num_tests = {3'd5, 3'd5, 3'd5}; stop_on_fail = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (req && phase == 2'd1 && test_id == 3'd1) break;
      @(negedge clk);
    end
    check_val("mid_pass_before_rst", pass_count, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_req", req, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_counts", pass_count + fail_count + timeout_count + skip_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gen_outs(20, 10);
    do_run(3'b101, {3'd2, 3'd1, 3'd3}, 1'b0, 1'b0, bc);

    for (int r = 0; r < 40; r++) begin
      gen_outs(20, 10);
      en = NS'($urandom);
      do_run(en, (NS*TW)'($urandom), 1'($urandom), 1'($urandom), bc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/svunit_hw_test_sequencer.md
Name: svunit_hw_test_sequencer

Overview:
Synthesizable hardware test runner for SVUnit-style self-checking benches and emulation harnesses. It walks NUM_SUITES test suites. For each enabled suite it runs one setup transaction, up to MAX_TESTS test transactions and one teardown transaction, all over a req/ack handshake to test agents. It accumulates pass/fail/timeout/skip counts, per-suite verdicts and an overall verdict, then pulses done. It is the parametrised successor of the software run-all-tests flow and adds suite enables, timeouts, stop-on-fail and skip accounting.

Parameters:
NUM_SUITES, 4, number of suites; SW = max(1, $clog2(NUM_SUITES))
MAX_TESTS, 8, max tests per suite; TW = $clog2(MAX_TESTS+1)
TIMEOUT_CYCLES, 1024, cycles req may stay unacknowledged before forced fail; must be >= 2
CNT_W, 16, width of result counters; counters saturate at all-ones

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle run request; honoured only when busy=0
suite_enable  in  NUM_SUITES  bit i enables suite i; sampled at start
suite_num_tests  in  NUM_SUITES*TW  packed per-suite test count; sampled at start; values above MAX_TESTS clamp to MAX_TESTS
stop_on_fail  in  1  sampled at start
req  out  1  transaction request to agents
phase  out  2  0=setup, 1=test, 2=teardown; stable while req=1
suite_id  out  SW  current suite; stable while req=1
test_id  out  TW  current test, 0 during setup/teardown; stable while req=1
ack  in  1  agent completion; counts only in a cycle where req=1
ack_pass  in  1  result; sampled with ack
busy  out  1  high from the cycle after start through the done cycle
done  out  1  one-cycle pulse at end of run
overall_pass  out  1  valid from done until next start
suite_pass  out  NUM_SUITES  per-suite verdict
pass_count, fail_count, timeout_count, skip_count  out  CNT_W each  test-level tallies

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0, including counters, suite_pass and overall_pass.
- States: IDLE, SCAN, SETUP, TEST, TEARDOWN, GAP, REPORT.
- IDLE, start=1: latch configuration; clear all counters, suite_pass and overall_pass; suite index=0; go to SCAN and set busy=1 on the next cycle.
- SCAN: one cycle per suite index.
  - Enabled suite: go to SETUP.
  - Disabled suite: suite_pass[i]=0, advance index.
  - Index past NUM_SUITES-1: go to REPORT.
- Handshake:
  - req rises on the first cycle of SETUP, TEST or TEARDOWN.
  - A transaction completes on the cycle where req=1 and ack=1.
  - req is 0 in the following cycle (GAP, exactly 1 cycle), then the next transaction's req rises.
  - ack while req=0 is ignored.
- Timeout:
  - A counter starts at 0 on req rise and increments each cycle that req=1 and ack=0.
  - When it reaches TIMEOUT_CYCLES-1 without ack, the transaction completes as a fail; timeout_count increments only for phase=test.
  - ack arriving in the same cycle as the timeout wins, and ack_pass is used.
- SETUP completion:
  - Pass: go to TEST with test_id=0. If the clamped count is 0, go straight to TEARDOWN.
  - Fail: mark the suite failed, add the clamped count to skip_count, go to TEARDOWN.
- TEST completion:
  - ack_pass=1: pass_count++.
  - ack_pass=0 or timeout: fail_count++, suite failed.
  - Next test_id, or TEARDOWN after the last test.
  - stop_on_fail=1 and failure: add the remaining tests of this suite to skip_count, go to TEARDOWN.
- TEARDOWN: always issued for an enabled suite.
  - Fail sets the suite failed; it does not change the test counters.
  - After teardown: suite_pass[i] = not failed.
  - If stop_on_fail=1 and the suite failed, add the clamped counts of all later enabled suites to skip_count and go to REPORT. Otherwise advance index and go to SCAN.
- REPORT: done=1 for one cycle; overall_pass = (fail_count==0 and every enabled suite passed and at least one suite enabled); busy=0 next cycle; return to IDLE.
- Counters saturate at 2^CNT_W-1.
- Results hold in IDLE until the next accepted start.
- start during busy is ignored.
- Reset mid-run: immediate abort, req drops asynchronously, all results cleared.

Test Plan:
- NUM_SUITES=2, enable=2'b11, counts {3,2}, agent acks after 1 cycle with pass=1 -> transactions in order S0:setup,t0,t1,t2,teardown then S1:setup,t0,t1,teardown; 1-cycle req gap each; pass_count=5, fail=0, suite_pass=2'b11, overall_pass=1, one done pulse.
- Suite 0, count 4; test 1 acked pass=0; stop_on_fail=1; suite 1 enabled with count 2 -> fail_count=1, pass_count=1, skip_count=2+2=4, teardown of S0 issued, no S1 transactions, overall_pass=0.
- TIMEOUT_CYCLES=8, agent never acks test 0 -> req high exactly 8 cycles then drops; timeout_count=1, fail_count=1; run continues to next test.
- Setup acked pass=0, count 3 -> no test transactions, skip_count=3, teardown still issued, suite_pass[0]=0.
- enable=0 -> no req ever; done pulses after NUM_SUITES+1 scan cycles; overall_pass=0. A start pulse during busy of a normal run -> ignored, counts unchanged.
- Assert rst_n low while req=1 mid-test -> req, busy and all counters 0 immediately; a new start after release runs cleanly from suite 0.
